// File: rtl/servo_pwm_bank.sv
// servo_pwm_bank: N-channel RC-servo PWM generator behind an APB3 slave.
// Pulse widths (cur) only change at frame boundaries, so outputs never glitch.
module servo_pwm_bank #(
  parameter int NUM_CH     = 4,
  parameter int TICK_DIV   = 100,
  parameter int PERIOD_DEF = 20000,
  parameter int MIN_PULSE  = 1000,
  parameter int MAX_PULSE  = 2000,
  parameter int CENTER     = 1500,
  parameter int STEP_DEF   = 10
) (
  input  logic              PCLK,
  input  logic              PRESERN,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [31:0]       PADDR,
  input  logic [31:0]       PWDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic [31:0]       PRDATA,
  output logic [NUM_CH-1:0] servo_pwm
);

  localparam int PSC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic                   en_q, en_d, slew_q, slew_d, en_prev_q;
  logic [15:0]            per_q, per_d, step_q, step_d;
  logic [15:0]            per_act_q, per_act_d, fcnt_q, fcnt_d;
  logic [PSC_W-1:0]       psc_q, psc_d;
  logic [NUM_CH-1:0][15:0] tgt_q, tgt_d, cur_q, cur_d;
  logic [NUM_CH-1:0]      pwm_q, pwm_d, status;

  // Target writes saturate into the legal servo range.
  function automatic logic [15:0] clamp_tgt(input logic [31:0] v);
    if (v < 32'(MIN_PULSE))      return 16'(MIN_PULSE);
    else if (v > 32'(MAX_PULSE)) return 16'(MAX_PULSE);
    else                         return v[15:0];
  endfunction

  // Move cur toward tgt by at most step, landing exactly on tgt (17-bit compare).
  function automatic logic [15:0] slew(input logic [15:0] cur, input logic [15:0] tgt,
                                       input logic [15:0] step);
    logic [16:0] diff;
    if (tgt >= cur) begin
      diff = {1'b0, tgt} - {1'b0, cur};
      if ({1'b0, step} < diff) return cur + step;
      else                     return tgt;
    end else begin
      diff = {1'b0, cur} - {1'b0, tgt};
      if ({1'b0, step} < diff) return cur - step;
      else                     return tgt;
    end
  endfunction

  // Address decode: channel windows at 0x20+8*i, 0x20 maps to index 0.
  logic [7:0] off;
  logic       is_ctrl, is_status, is_period, is_step, in_ch_win, ch_ok, is_cur;
  logic [2:0] ch_idx;
  logic       mapped, ro_hit, per_bad, acc, err, wr_ok;
  logic       unused_bits;

  assign off         = PADDR[7:0];
  assign unused_bits = ^PADDR[31:8];
  assign is_ctrl     = (off == 8'h00);
  assign is_status   = (off == 8'h04);
  assign is_period   = (off == 8'h08);
  assign is_step     = (off == 8'h0C);
  assign in_ch_win   = (off >= 8'h20) && (off <= 8'h5C) && (off[1:0] == 2'b00);
  assign ch_idx      = off[5:3] + 3'd4;
  assign is_cur      = off[2];
  assign ch_ok       = in_ch_win && ({29'd0, ch_idx} < 32'(NUM_CH));
  assign mapped      = is_ctrl | is_status | is_period | is_step | ch_ok;
  assign ro_hit      = is_status | (ch_ok & is_cur);
  assign per_bad     = is_period & (PWDATA[15:0] <= 16'(MAX_PULSE));
  assign acc         = PSEL & PENABLE;
  assign err         = acc & (~mapped | (PWRITE & (ro_hit | per_bad)));
  assign wr_ok       = acc & PWRITE & ~err;
  assign PSLVERR     = err;
  assign PREADY      = 1'b1;
  assign servo_pwm   = pwm_q;

  // Register-file next state from committed APB writes.
  always_comb begin
    en_d   = en_q;
    slew_d = slew_q;
    per_d  = per_q;
    step_d = step_q;
    tgt_d  = tgt_q;
    if (wr_ok) begin
      if (is_ctrl) begin
        en_d   = PWDATA[0];
        slew_d = PWDATA[1];
      end
      if (is_period) per_d  = PWDATA[15:0];
      if (is_step)   step_d = PWDATA[15:0];
      for (int i = 0; i < NUM_CH; i++)
        if (ch_ok && !is_cur && ch_idx == 3'(i)) tgt_d[i] = clamp_tgt(PWDATA);
    end
  end

  // Timebase, frame-boundary pulse update and output compare.
  logic en_rise, tick, wrap, boundary;
  always_comb begin
    en_rise   = en_q & ~en_prev_q;
    tick      = (psc_q == PSC_W'(TICK_DIV - 1));
    wrap      = en_q & ~en_rise & tick & (fcnt_q == per_act_q - 16'd1);
    boundary  = wrap | en_rise;
    psc_d     = (!en_q || en_rise || tick) ? '0 : psc_q + 1'b1;
    fcnt_d    = fcnt_q;
    if (!en_q || en_rise || wrap) fcnt_d = '0;
    else if (tick)                fcnt_d = fcnt_q + 16'd1;
    per_act_d = boundary ? per_q : per_act_q;
    cur_d     = cur_q;
    pwm_d     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (boundary) cur_d[i] = slew_q ? slew(cur_q[i], tgt_q[i], step_q) : tgt_q[i];
      pwm_d[i] = en_q & ~en_rise & (fcnt_q < cur_q[i]);
    end
  end

  // Read mux: combinational while PSEL is high, zero otherwise or when unmapped.
  always_comb begin
    PRDATA = '0;
    for (int i = 0; i < NUM_CH; i++) status[i] = (cur_q[i] != tgt_q[i]);
    if (PSEL) begin
      if (is_ctrl)   PRDATA = {30'd0, slew_q, en_q};
      if (is_status) PRDATA[NUM_CH-1:0] = status;
      if (is_period) PRDATA = {16'd0, per_q};
      if (is_step)   PRDATA = {16'd0, step_q};
      for (int i = 0; i < NUM_CH; i++)
        if (ch_ok && ch_idx == 3'(i)) PRDATA = {16'd0, is_cur ? cur_q[i] : tgt_q[i]};
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge PCLK) begin
    if (PRESERN) begin
      en_q      <= 1'b0;
      slew_q    <= 1'b0;
      en_prev_q <= 1'b0;
      per_q     <= 16'(PERIOD_DEF);
      step_q    <= 16'(STEP_DEF);
      per_act_q <= 16'(PERIOD_DEF);
      fcnt_q    <= '0;
      psc_q     <= '0;
      tgt_q     <= {NUM_CH{16'(CENTER)}};
      cur_q     <= {NUM_CH{16'(CENTER)}};
      pwm_q     <= '0;
    end else begin
      en_q      <= en_d;
      slew_q    <= slew_d;
      en_prev_q <= en_q;
      per_q     <= per_d;
      step_q    <= step_d;
      per_act_q <= per_act_d;
      fcnt_q    <= fcnt_d;
      psc_q     <= psc_d;
      tgt_q     <= tgt_d;
      cur_q     <= cur_d;
      pwm_q     <= pwm_d;
    end
  end

endmodule

// File: tb/tb_servo_pwm_bank.sv
// tb_servo_pwm_bank: directed scoreboard bench for servo_pwm_bank (TICK_DIV=4).
module tb_servo_pwm_bank;
  localparam int NUM_CH   = 4;
  localparam int TICK_DIV = 4;

  logic              PCLK = 1'b0;
  logic              PRESERN, PSEL, PENABLE, PWRITE;
  logic [31:0]       PADDR, PWDATA;
  logic              PREADY, PSLVERR;
  logic [31:0]       PRDATA;
  logic [NUM_CH-1:0] servo_pwm;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    bit          is_rd;
    logic [31:0] rdata;
    bit          err;
  } exp_t;
  exp_t exp_q[$];

  always #5 PCLK = ~PCLK;

  servo_pwm_bank #(.NUM_CH(NUM_CH), .TICK_DIV(TICK_DIV)) dut (
    .PCLK(PCLK), .PRESERN(PRESERN), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .PRDATA(PRDATA), .servo_pwm(servo_pwm)
  );

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endfunction

  // Monitor: every APB access phase pops one expectation and compares it.
  exp_t e;
  always @(negedge PCLK) begin
    if (PSEL && PENABLE) begin
      if (exp_q.size() == 0) check("apb_unexpected_access", 1, 0);
      else begin
        e = exp_q.pop_front();
        check({e.name, "_pready"}, PREADY, 1);
        check({e.name, "_slverr"}, PSLVERR, e.err);
        if (e.is_rd) check({e.name, "_rdata"}, PRDATA, e.rdata);
      end
    end
  end

  task automatic apb(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                     input logic [31:0] exp_rd, input bit exp_err, input string name);
    exp_t x;
    x.name = name; x.is_rd = !wr; x.rdata = exp_rd; x.err = exp_err;
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = data;
    exp_q.push_back(x);
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input bit err, input string name);
    apb(1'b1, addr, data, 32'd0, err, name);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input bit err, input string name);
    apb(1'b0, addr, 32'd0, exp, err, name);
  endtask

  // Bounded wait for servo_pwm[ch] to reach val, sampled on falling edges.
  task automatic wait_pwm(input int ch, input logic val, input string name);
    int n = 0;
    while (servo_pwm[ch] !== val && n < 20000) begin
      @(negedge PCLK);
      n++;
    end
    check(name, servo_pwm[ch], val);
  endtask

  // Count consecutive high samples starting at the current (high) sample.
  task automatic count_high(input int ch, output int cnt);
    cnt = 1;
    for (int n = 0; n < 20000; n++) begin
      @(negedge PCLK);
      if (servo_pwm[ch]) cnt++;
      else break;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_k;
    int hi [NUM_CH];
    int cnt;
    logic [31:0] slew_exp [4];
    slew_exp = '{32'd1700, 32'd1800, 32'd1900, 32'd1950};

    PRESERN = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
    repeat (3) @(posedge PCLK);
    #1 PRESERN = 1'b0;
    @(negedge PCLK);
    check("pwm_after_reset", servo_pwm, 0);

    // Reset values of every register.
    rd(32'h00, 0,     0, "ctrl_rst");
    rd(32'h04, 0,     0, "status_rst");
    rd(32'h08, 20000, 0, "period_rst");
    rd(32'h0C, 10,    0, "step_rst");
    for (int i = 0; i < NUM_CH; i++) begin
      rd(32'h20 + 8*i, 1500, 0, $sformatf("tgt%0d_rst", i));
      rd(32'h24 + 8*i, 1500, 0, $sformatf("cur%0d_rst", i));
    end

    // Error accesses leave state untouched.
    wr(32'h04, 32'hF,  1, "wr_status");
    rd(32'h04, 0,      0, "status_after_wr");
    wr(32'h08, 1500,   1, "wr_period_1500");
    wr(32'h08, 2000,   1, "wr_period_eq_max");
    rd(32'h08, 20000,  0, "period_after_bad");
    rd(32'h40, 0,      1, "rd_ch4");
    wr(32'h40, 1200,   1, "wr_ch4");
    wr(32'h24, 1000,   1, "wr_current0");
    rd(32'h24, 1500,   0, "cur0_after_bad");
    rd(32'h10, 0,      1, "rd_unmapped");

    // Pulse widths: ch0 1200 ticks, others 1500 ticks, 2500-tick frame.
    wr(32'h08, 2500, 0, "wr_period_2500");
    wr(32'h20, 1200, 0, "wr_tgt0");
    wr(32'h00, 1,    0, "wr_ctrl_en");
    first_k = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge PCLK);
      if (servo_pwm[0]) begin first_k = k; break; end
    end
    check("first_high_delay", first_k, 3);
    for (int c = 0; c < NUM_CH; c++) hi[c] = 0;
    for (int s = 0; s < 2500*TICK_DIV; s++) begin
      if (s > 0) @(negedge PCLK);
      for (int c = 0; c < NUM_CH; c++) hi[c] += int'(servo_pwm[c]);
    end
    check("ch0_high_cycles", hi[0], 1200*TICK_DIV);
    for (int c = 1; c < NUM_CH; c++) check($sformatf("ch%0d_high_cycles", c), hi[c], 1500*TICK_DIV);

    // Target clamping.
    wr(32'h28, 5,    0, "wr_tgt1_5");
    rd(32'h28, 1000, 0, "tgt1_clamp_lo");
    wr(32'h28, 9000, 0, "wr_tgt1_9000");
    rd(32'h28, 2000, 0, "tgt1_clamp_hi");
    wr(32'h28, 1500, 0, "wr_tgt1_restore");

    // Slew limiting on ch2.
    wr(32'h00, 0,    0, "wr_ctrl_off");
    wr(32'h08, 2001, 0, "wr_period_2001");
    wr(32'h0C, 100,  0, "wr_step_100");
    wr(32'h30, 1950, 0, "wr_tgt2");
    rd(32'h04, 4,    0, "status_pending");
    rd(32'h34, 1500, 0, "cur2_before_en");
    wr(32'h00, 3,    0, "wr_ctrl_slew");
    rd(32'h34, 1600, 0, "cur2_step0");
    rd(32'h04, 4,    0, "status_step0");
    for (int f = 0; f < 4; f++) begin
      wait_pwm(2, 1'b0, $sformatf("slew_fall%0d", f));
      wait_pwm(2, 1'b1, $sformatf("slew_rise%0d", f));
      rd(32'h34, slew_exp[f], 0, $sformatf("cur2_step%0d", f + 1));
      rd(32'h04, (f == 3) ? 32'd0 : 32'd4, 0, $sformatf("status_step%0d", f + 1));
    end

    // Mid-frame TARGET3 write takes effect at the next frame.
    wr(32'h00, 1, 0, "wr_ctrl_noslew");
    wait_pwm(3, 1'b0, "t3_fall_a");
    wait_pwm(3, 1'b1, "t3_rise_a");
    fork
      count_high(3, cnt);
      begin
        repeat (100) @(posedge PCLK);
        wr(32'h38, 1100, 0, "wr_tgt3_mid");
      end
    join
    check("ch3_width_cur_frame", cnt, 1500*TICK_DIV);
    wait_pwm(3, 1'b1, "t3_rise_b");
    count_high(3, cnt);
    check("ch3_width_next_frame", cnt, 1100*TICK_DIV);
    rd(32'h3C, 1100, 0, "cur3_new");

    // Reset while ch2 is mid-pulse.
    wait_pwm(2, 1'b1, "pre_reset_high");
    @(posedge PCLK); #1 PRESERN = 1'b1;
    @(posedge PCLK);
    @(negedge PCLK);
    check("pwm_at_reset_edge", servo_pwm, 0);
    @(posedge PCLK); #1 PRESERN = 1'b0;
    rd(32'h00, 0,     0, "ctrl_rst2");
    rd(32'h08, 20000, 0, "period_rst2");
    rd(32'h0C, 10,    0, "step_rst2");
    rd(32'h38, 1500,  0, "tgt3_rst2");
    rd(32'h34, 1500,  0, "cur2_rst2");
    rd(32'h04, 0,     0, "status_rst2");
    @(negedge PCLK);
    check("pwm_after_reset2", servo_pwm, 0);

    repeat (3) @(posedge PCLK);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/servo_pwm_bank.md
Name: servo_pwm_bank

Overview:
- Parametrised N-channel RC-servo PWM generator. APB3 slave on a CoreAPB3 slot, clocked from the MSS fabric clock.
- Successor to the fixed two-axis servo controller: channel count is a parameter, and it adds per-frame target/current pulse registers, optional slew-rate limiting, a programmable frame period and target clamping.
- All pulse updates take effect only at frame boundaries, so output pulses never glitch.

Parameters:
- NUM_CH, 4, number of PWM channels (1..8)
- TICK_DIV, 100, PCLK cycles per timing tick (100 MHz gives 1 us ticks)
- PERIOD_DEF, 20000, reset frame length in ticks
- MIN_PULSE, 1000, lowest allowed target in ticks
- MAX_PULSE, 2000, highest allowed target in ticks
- CENTER, 1500, reset target/current value
- STEP_DEF, 10, reset slew step in ticks per frame

Ports:
- PCLK  in  1  clock
- PRESERN  in  1  reset; one clock; reset is synchronous and active-high
- PSEL  in  1  APB select
- PENABLE  in  1  APB enable
- PWRITE  in  1  APB write
- PADDR  in  32  APB address; only [7:0] decoded
- PWDATA  in  32  APB write data
- PREADY  out  1  constant 1 (zero wait state)
- PSLVERR  out  1  error for the access phase
- PRDATA  out  32  read data
- servo_pwm  out  NUM_CH  PWM outputs; bit i is channel i

Behaviour:
- Register map (byte offsets):
  - 0x00 CTRL RW: bit0 EN, bit1 SLEW_EN.
  - 0x04 STATUS RO: bit i is 1 when cur[i] != tgt[i].
  - 0x08 PERIOD RW [15:0].
  - 0x0C STEP RW [15:0].
  - 0x20+8*i TARGET RW [15:0].
  - 0x24+8*i CURRENT RO [15:0].
- Reset state: CTRL=0, PERIOD=PERIOD_DEF, STEP=STEP_DEF, tgt[i]=cur[i]=CENTER, counters=0, servo_pwm=0, PSLVERR=0.
- APB transfer:
  - A write commits on the PCLK edge where PSEL&PENABLE&PWRITE is high.
  - Reads are combinational from PADDR while PSEL is high. PRDATA=0 when PSEL is low or the address is unmapped.
  - Unused upper bits read 0.
- PSLVERR=1 during the access phase in these cases; the write is discarded:
  - any access to an unmapped offset or to a channel index >= NUM_CH;
  - a write to STATUS or CURRENT;
  - a PERIOD write with a value <= MAX_PULSE.
- TARGET writes are clamped to [MIN_PULSE, MAX_PULSE]. No error is flagged, and readback returns the clamped value.
- A STEP write of 0 is stored as 0. With SLEW_EN=1 this freezes cur.
- Timebase:
  - Prescaler counts 0..TICK_DIV-1; tick=1 on the terminal count.
  - Frame counter fcnt (16 bit) increments on tick and wraps from PERIOD_act-1 to 0.
  - PERIOD_act (the active period) loads from PERIOD at each wrap.
- Frame boundary is the cycle where fcnt wraps to 0, or the first cycle after EN rises. For every channel, cur updates:
  - SLEW_EN=0: cur=tgt.
  - SLEW_EN=1: cur moves toward tgt by min(STEP, |tgt-cur|).
  - The subtraction is unsigned 17 bit, with no overshoot and no wrap.
- Output: servo_pwm[i] is registered = EN & (fcnt < cur[i]). It has 1-cycle latency from the fcnt change.
- EN=0:
  - prescaler, fcnt and outputs are held at 0 from the next cycle;
  - cur holds its value; TARGET writes are still accepted.
- EN 0->1:
  - the frame starts at fcnt=0 with a boundary update;
  - the first output high occurs 2 cycles after the CTRL write commits.
- A TARGET write landing on the same edge as a boundary update: the boundary uses the old tgt, and the new tgt applies at the next boundary.
- Reset mid-frame: all state returns to reset values on the next edge, and outputs are low from that edge.
- STATUS reflects the registered cur/tgt with no extra latency.

Test Plan:
- Reset, then read all registers -> CTRL=0, PERIOD=20000, STEP=10, TARGET/CURRENT=1500 for channels 0..3, STATUS=0; servo_pwm=0.
- Set TICK_DIV=4, PERIOD=2500 (>2000); write TARGET0=1200, CTRL=1 -> ch0 high exactly 1200*4 cycles per 2500*4-cycle frame; other channels high 1500 ticks.
- Write TARGET1=5, then TARGET1=9000 -> readback 1000, then 2000; PSLVERR=0.
- CTRL=3, STEP=100, TARGET2 1500->1950 -> CURRENT2 reads 1600, 1700, 1800, 1900, 1950 on successive frames; STATUS bit2 clears in the frame where 1950 is reached.
- Access error cases -> PSLVERR=1 and no state change:
  - write to 0x04;
  - write PERIOD=1500;
  - access 0x40 with NUM_CH=4.
- Write TARGET3 mid-frame -> the pulse in the current frame is unchanged and the new width appears next frame. Assert PRESERN mid-pulse -> all outputs 0 on the next edge and registers at reset values.
